// File: rtl/vga_fetch_arbiter.sv
// Shares one single-port framebuffer between VGA scan-out prefetch and the SIMD writer.
// Scan-out reads are kept ahead of the raster in a small FIFO; writes take the slack slots.
module vga_fetch_arbiter #(
    parameter int          IMG_W      = 256,
    parameter int          IMG_H      = 256,
    parameter int          X0         = 152,
    parameter int          Y0         = 40,
    parameter int          ADDR_W     = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          LOW_WM     = 4,
    parameter int          MEM_LAT    = 2,
    parameter logic [23:0] BG_COLOR   = 24'hFF0000
) (
    input  logic              FPGA_Clock,
    input  logic              Reset_N,
    input  logic              pix_en,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    output logic [23:0]       RGB_OUT,
    output logic              pix_visible,
    output logic              underrun
);

    localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LVL_W = CNT_W + 1;

    localparam logic [ADDR_W:0]  RD_END   = (ADDR_W+1)'(IMG_W * IMG_H);
    localparam logic [10:0]      X_LO     = 11'(X0);
    localparam logic [10:0]      X_HI     = 11'(X0 + IMG_W);
    localparam logic [10:0]      Y_LO     = 11'(Y0);
    localparam logic [10:0]      Y_HI     = 11'(Y0 + IMG_H);
    localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(LOW_WM);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        PREFETCH,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W:0]    rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   inflight;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [23:0]        fifo_mem [FIFO_DEPTH];
    logic               epoch;
    logic [MEM_LAT-1:0] vld_p;
    logic [MEM_LAT-1:0] ep_p;

    logic               frame_start;
    logic               in_window;
    logic               fifo_empty;
    logic [LVL_W-1:0]   level;
    logic               can_read;
    logic               rd_go;
    logic               wr_go;
    logic               push_en;
    logic               pop_en;
    logic               ret_vld;

    assign frame_start = pix_en && (h_count == 10'd0) && (v_count == 10'd0);
    assign in_window   = ({1'b0, h_count} >= X_LO) && ({1'b0, h_count} < X_HI) &&
                         ({1'b0, v_count} >= Y_LO) && ({1'b0, v_count} < Y_HI);
    assign fifo_empty  = (occ == '0);
    // Stale-frame tags are still counted in flight until they leave the pipe.
    assign level       = LVL_W'(occ) + LVL_W'(inflight);
    assign ret_vld     = vld_p[MEM_LAT-1];
    assign push_en     = ret_vld && (ep_p[MEM_LAT-1] == epoch) && !frame_start;
    assign pop_en      = pix_en && in_window && !frame_start && !fifo_empty;

    always_ff @(posedge FPGA_Clock) begin
        if (!Reset_N) state_q <= WAIT_FRAME;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        rd_go    = 1'b0;
        wr_go    = 1'b0;
        can_read = (state_q == PREFETCH) && (rd_ptr != RD_END) && !frame_start;

        // A held request is not granted again while its ack is still showing.
        if (can_read && (level < LVL_LOW))       rd_go = 1'b1;
        else if (wr_req && !wr_ack)              wr_go = 1'b1;
        else if (can_read && (level < LVL_FULL)) rd_go = 1'b1;

        if (frame_start)                                     state_d = PREFETCH;
        else if ((state_q == PREFETCH) && (rd_ptr == RD_END)) state_d = DRAIN;
    end

    // Stage p0..pN: read-return tracking, FIFO control and registered outputs
    always_ff @(posedge FPGA_Clock) begin
        if (!Reset_N) begin
            rd_ptr      <= '0;
            epoch       <= 1'b0;
            vld_p       <= '0;
            inflight    <= '0;
            occ         <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            underrun    <= 1'b0;
            wr_ack      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            RGB_OUT     <= '0;
            pix_visible <= 1'b0;
        end else begin
            vld_p[0] <= rd_go;
            for (int i = 1; i < MEM_LAT; i++) vld_p[i] <= vld_p[i-1];

            case ({rd_go, ret_vld})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (frame_start) begin
                rd_ptr <= '0;
                epoch  <= ~epoch;
                occ    <= '0;
                wr_idx <= '0;
                rd_idx <= '0;
            end else begin
                if (rd_go)   rd_ptr <= rd_ptr + 1'b1;
                if (push_en) wr_idx <= wr_idx + 1'b1;
                if (pop_en)  rd_idx <= rd_idx + 1'b1;
                case ({push_en, pop_en})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end

            wr_ack <= wr_go;
            mem_we <= wr_go;
            if (wr_go) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (rd_go) begin
                mem_addr  <= rd_ptr[ADDR_W-1:0];
            end

            if (pix_en) begin
                if (pop_en) begin
                    RGB_OUT     <= fifo_mem[rd_idx];
                    pix_visible <= 1'b1;
                end else begin
                    RGB_OUT     <= BG_COLOR;
                    pix_visible <= 1'b0;
                    if (in_window && !frame_start) underrun <= 1'b1;
                end
            end
        end
    end

    // Data path: epoch tags and FIFO storage carry no reset
    always_ff @(posedge FPGA_Clock) begin
        ep_p[0] <= epoch;
        for (int i = 1; i < MEM_LAT; i++) ep_p[i] <= ep_p[i-1];
        if (push_en) fifo_mem[wr_idx] <= mem_rdata;
    end

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter: a compressed raster over a modelled framebuffer
// whose cell i holds i, with a 2-cycle synchronous read path.
module tb_vga_fetch_arbiter;

    localparam int          ADDR_W = 16;
    localparam logic [23:0] BG     = 24'hFF0000;

    logic              FPGA_Clock;
    logic              Reset_N;
    logic              pix_en;
    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [23:0]       mem_wdata;
    logic [23:0]       mem_rdata;
    logic [23:0]       RGB_OUT;
    logic              pix_visible;
    logic              underrun;

    vga_fetch_arbiter #(
        .IMG_W(256), .IMG_H(256), .X0(152), .Y0(40), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(8), .LOW_WM(4), .MEM_LAT(2), .BG_COLOR(BG)
    ) dut (
        .FPGA_Clock (FPGA_Clock),
        .Reset_N    (Reset_N),
        .pix_en     (pix_en),
        .h_count    (h_count),
        .v_count    (v_count),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .RGB_OUT    (RGB_OUT),
        .pix_visible(pix_visible),
        .underrun   (underrun)
    );

    initial begin
        FPGA_Clock = 1'b0;
        forever #5 FPGA_Clock = ~FPGA_Clock;
    end

    // Framebuffer model: one registered read stage plus the DUT's capture edge gives MEM_LAT=2.
    logic [23:0] mem [65536];
    logic [23:0] rdata_q;
    logic        mem_load;

    always @(posedge FPGA_Clock) begin
        if (mem_load) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 24'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rdata_q <= mem[mem_addr];
    end
    assign mem_rdata = rdata_q;

    int ack_cnt = 0;
    always @(negedge FPGA_Clock) if (wr_ack) ack_cnt++;

    typedef struct {
        int          h;
        int          v;
        logic [23:0] rgb;
        logic        vis;
    } chk_t;

    chk_t        tab [9];
    int          total = 0;
    int          bad   = 0;
    logic [23:0] got_rgb;
    logic        got_vis;
    int          ack_base;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge FPGA_Clock);
        #1;
    endtask

    task automatic pix(input int h, input int v, input bit gap);
        pix_en  = 1'b1;
        h_count = 10'(h);
        v_count = 10'(v);
        tick();
        pix_en  = 1'b0;
        got_rgb = RGB_OUT;
        got_vis = pix_visible;
        if (gap) tick();
    endtask

    task automatic tab_check(input int h, input int v);
        for (int k = 0; k < 9; k++) begin
            if (tab[k].h == h && tab[k].v == v)
                check($sformatf("pix(%0d,%0d)", h, v), {7'd0, got_rgb, got_vis},
                      {7'd0, tab[k].rgb, tab[k].vis});
        end
    endtask

    task automatic run_frame(input bit gap);
        pix(0, 0, gap);
        for (int x = 1; x <= 30; x++)   begin pix(x, 0, gap);  tab_check(x, 0);  end
        for (int x = 140; x <= 420; x++) begin pix(x, 40, gap); tab_check(x, 40); end
        for (int x = 140; x <= 170; x++) begin pix(x, 41, gap); tab_check(x, 41); end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"},      32'(RGB_OUT),     32'd0);
        check({tag, "_vis"},      32'(pix_visible), 32'd0);
        check({tag, "_wr_ack"},   32'(wr_ack),      32'd0);
        check({tag, "_mem_we"},   32'(mem_we),      32'd0);
        check({tag, "_underrun"}, 32'(underrun),    32'd0);
    endtask

    initial begin
        tab[0] = '{h: 10,  v: 0,  rgb: BG,          vis: 1'b0};
        tab[1] = '{h: 151, v: 40, rgb: BG,          vis: 1'b0};
        tab[2] = '{h: 152, v: 40, rgb: 24'd0,       vis: 1'b1};
        tab[3] = '{h: 153, v: 40, rgb: 24'd1,       vis: 1'b1};
        tab[4] = '{h: 157, v: 40, rgb: 24'h00FF00,  vis: 1'b1};
        tab[5] = '{h: 407, v: 40, rgb: 24'd255,     vis: 1'b1};
        tab[6] = '{h: 408, v: 40, rgb: BG,          vis: 1'b0};
        tab[7] = '{h: 152, v: 41, rgb: 24'd256,     vis: 1'b1};
        tab[8] = '{h: 160, v: 41, rgb: 24'd264,     vis: 1'b1};

        mem_load = 1'b1;
        Reset_N  = 1'b0;
        pix_en   = 1'b0;
        h_count  = '0;
        v_count  = '0;
        wr_req   = 1'b1;
        wr_addr  = 16'hF000;
        wr_data  = 24'hABCDEF;

        // T1: reset held two edges with a pending write
        tick();
        mem_load = 1'b0;
        tick();
        check_reset_state("t1");
        check("t1_mem_addr", 32'(mem_addr), 32'd0);
        wr_req  = 1'b0;
        Reset_N = 1'b1;
        tick();

        // T4: write in WAIT_FRAME is acked on the next edge
        wr_addr = 16'd5;
        wr_data = 24'h00FF00;
        wr_req  = 1'b1;
        tick();
        check("t4_wr_ack",    32'(wr_ack),    32'd1);
        check("t4_mem_we",    32'(mem_we),    32'd1);
        check("t4_mem_addr",  32'(mem_addr),  32'd5);
        check("t4_mem_wdata", 32'(mem_wdata), 32'h00FF00);
        wr_req = 1'b0;
        tick();
        check("t4_ack_once",  32'(wr_ack),    32'd0);

        // T2: pix_en every second cycle, no writer
        run_frame(1'b1);
        check("t2_underrun", 32'(underrun), 32'd0);

        // T3: same frame with the writer requesting throughout
        wr_addr  = 16'hF000;
        wr_data  = 24'h123456;
        wr_req   = 1'b1;
        ack_base = ack_cnt;
        run_frame(1'b1);
        check("t3_underrun",  32'(underrun), 32'd0);
        check("t3_acks_seen", 32'(ack_cnt > ack_base), 32'd1);

        // T6: pix_en every cycle, writer still requesting
        pix(0, 0, 1'b0);
        for (int x = 1; x <= 30; x++) pix(x, 0, 1'b0);
        for (int x = 140; x <= 420; x++) begin
            if (x == 200) ack_base = ack_cnt;
            pix(x, 40, 1'b0);
            if (x >= 152 && x <= 407)
                check($sformatf("t6_pix(%0d,40)", x), {7'd0, got_rgb, got_vis},
                      {7'd0, (x == 157) ? 24'h00FF00 : 24'(x - 152), 1'b1});
            if (x == 407) check("t6_no_ack_in_line", 32'(ack_cnt - ack_base), 32'd0);
        end
        check("t6_underrun", 32'(underrun), 32'd0);
        for (int x = 140; x <= 250; x++) begin
            pix(x, 41, 1'b0);
            if (x == 152) check("t6_pix(152,41)", {7'd0, got_rgb, got_vis}, {7'd0, 24'd256, 1'b1});
        end

        // T5: frame restart while reads of the old frame are in flight
        pix(0, 0, 1'b0);
        for (int x = 1; x <= 30; x++) pix(x, 0, 1'b0);
        for (int x = 152; x <= 155; x++) begin
            pix(x, 40, 1'b0);
            check($sformatf("t5_pix(%0d,40)", x), {7'd0, got_rgb, got_vis},
                  {7'd0, 24'(x - 152), 1'b1});
        end
        for (int x = 156; x <= 199; x++) pix(x, 40, 1'b0);
        check("t5_underrun", 32'(underrun), 32'd0);

        // T6 tail: reset in the middle of a visible line
        Reset_N = 1'b0;
        pix(200, 40, 1'b0);
        check_reset_state("t6_rst");
        Reset_N = 1'b1;
        wr_req  = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
